// File: rtl/median_window_gen_pkg.sv
// Shared defaults and types for the median window generator slice.
// Define WIN_COORD_EN to add window centre coordinate outputs.
package denoise_pkg;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_IMG_W = 100;
  localparam int unsigned DEF_IMG_H = 100;

  localparam int unsigned WIN_PER_FRAME = (DEF_IMG_W - 2) * (DEF_IMG_H - 2);
  localparam int unsigned COL_W         = $clog2(DEF_IMG_W);
  localparam int unsigned ROW_W         = $clog2(DEF_IMG_H);

  typedef logic [DEF_PIX_W-1:0] pixel_t;

endpackage

// File: rtl/median_window_gen_if.sv
// Pixel-in / window-out bundle for median_window_gen.
// WIN_COORD_EN adds win_row/win_col alongside the window.
interface median_window_gen_if
  import denoise_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) ();

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             sof;

  logic [PIX_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic             win_valid;
  logic             frame_done;
`ifdef WIN_COORD_EN
  logic [$clog2(IMG_H)-1:0] win_row;
  logic [$clog2(IMG_W)-1:0] win_col;
`endif

  modport master (
    output pix_in, pix_valid, sof,
    input  p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, frame_done
`ifdef WIN_COORD_EN
    , input win_row, win_col
`endif
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, frame_done
`ifdef WIN_COORD_EN
    , output win_row, win_col
`endif
  );

endinterface

// File: rtl/median_line_buf.sv
// One image-row line buffer: combinational read, synchronous write to the
// same address, so a read in the write cycle returns the previous row's pixel.
module median_line_buf #(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, interior windows out.
// Optional WIN_COORD_EN exports the centre coordinate of each window.
module median_window_gen
  import denoise_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input logic                clk,
  input logic                rst_n,
  median_window_gen_if.slave bus
);

  localparam int unsigned COL_BITS = $clog2(IMG_W);
  localparam int unsigned ROW_BITS = $clog2(IMG_H);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_W - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_H - 1);
  localparam logic [COL_BITS-1:0] COL_TWO  = COL_BITS'(2);
  localparam logic [ROW_BITS-1:0] ROW_TWO  = ROW_BITS'(2);

  logic [COL_BITS-1:0] col_q, col_d, cur_col;
  logic [ROW_BITS-1:0] row_q, row_d, cur_row;
  logic [PIX_W-1:0]    tap_top, tap_mid;

  logic [PIX_W-1:0] top_q [3];
  logic [PIX_W-1:0] top_d [3];
  logic [PIX_W-1:0] mid_q [3];
  logic [PIX_W-1:0] mid_d [3];
  logic [PIX_W-1:0] bot_q [3];
  logic [PIX_W-1:0] bot_d [3];
  logic [PIX_W-1:0] p_q   [9];
  logic [PIX_W-1:0] p_d   [9];

  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;
`ifdef WIN_COORD_EN
  logic [ROW_BITS-1:0] win_row_q, win_row_d;
  logic [COL_BITS-1:0] win_col_q, win_col_d;
`endif

  // sof relocates this very pixel to (0,0), so it steers the buffer address too
  assign cur_col = bus.sof ? '0 : col_q;
  assign cur_row = bus.sof ? '0 : row_q;

  median_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(COL_BITS)) u_lb_a (
    .clk   (clk),
    .we    (bus.pix_valid),
    .addr  (cur_col),
    .wdata (tap_mid),
    .rdata (tap_top)
  );

  median_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(COL_BITS)) u_lb_b (
    .clk   (clk),
    .we    (bus.pix_valid),
    .addr  (cur_col),
    .wdata (bus.pix_in),
    .rdata (tap_mid)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    p_d          = p_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef WIN_COORD_EN
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
`endif
    if (bus.pix_valid) begin
      top_d = '{top_q[1], top_q[2], tap_top};
      mid_d = '{mid_q[1], mid_q[2], tap_mid};
      bot_d = '{bot_q[1], bot_q[2], bus.pix_in};
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      // Rows/cols 0-1 hold stale buffer or shift data; only interior positions load
      if (cur_row >= ROW_TWO && cur_col >= COL_TWO) begin
        p_d          = '{top_d[0], top_d[1], top_d[2],
                         mid_d[0], mid_d[1], mid_d[2],
                         bot_d[0], bot_d[1], bot_d[2]};
        win_valid_d  = 1'b1;
        frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
`ifdef WIN_COORD_EN
        win_row_d    = cur_row - 1'b1;
        win_col_d    = cur_col - 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '{default: '0};
      mid_q        <= '{default: '0};
      bot_q        <= '{default: '0};
      p_q          <= '{default: '0};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef WIN_COORD_EN
      win_row_q    <= '0;
      win_col_q    <= '0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      p_q          <= p_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
`ifdef WIN_COORD_EN
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
`endif
    end
  end

  assign bus.p0         = p_q[0];
  assign bus.p1         = p_q[1];
  assign bus.p2         = p_q[2];
  assign bus.p3         = p_q[3];
  assign bus.p4         = p_q[4];
  assign bus.p5         = p_q[5];
  assign bus.p6         = p_q[6];
  assign bus.p7         = p_q[7];
  assign bus.p8         = p_q[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
`ifdef WIN_COORD_EN
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
`endif

endmodule
